alu_operand_sequencer: RTL and testbench

//  Sequences the shared combinational ALU from a single switch bank and two debounced push-button pulses.
//  The operator enters operand A, then operand B, then the opcode, all on data_in. The block drives the
//  ALU operand and opcode inputs, then registers the result and status flags for the display and LED muxes.
//  It sits between the PB debouncers / switches and ALU_comb, and replaces direct SW->ALU wiring.

---
 rtl/alu_operand_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
//
// Purpose:
//   Drives the shared combinational ALU from one switch bank and two debounced
//   push-button pulses. The operator keys in operand A, then operand B, then
//   the opcode, all on data_in. After the opcode is accepted the ALU gets one
//   full cycle with stable inputs. Its result and status flags are then
//   registered for the display and LED muxes.
//
// Ports:
//   clk           in   1   system clock
//   rst           in   1   asynchronous, active-high reset
//   data_in       in   N   switch value; operand during entry, opcode in [1:0]
//   enter_pulse   in   1   one-cycle press: accept / advance
//   undo_pulse    in   1   one-cycle press: step back
//   alu_result    in   N   combinational ALU result
//   alu_status    in   4   combinational ALU flags {N,Z,C,V}
//   alu_a         out  N   registered operand A
//   alu_b         out  N   registered operand B
//   alu_opcode    out  2   registered opcode
//   result        out  N   captured ALU result
//   flags         out  4   captured ALU flags
//   result_valid  out  1   high while in SHOW
//   display_value out  N   value for the 7-segment driver
//   state_leds    out  4   one-hot {SHOW,WAIT_OP,WAIT_B,WAIT_A}
//
// States:
//   state   | meaning
//   WAIT_A  | waiting for operand A on enter
//   WAIT_B  | waiting for operand B on enter, undo returns to WAIT_A
//   WAIT_OP | waiting for opcode on enter, undo returns to WAIT_B
//   EXEC    | single cycle in which the ALU settles, then result is captured
//   SHOW    | result shown; enter clears and restarts, undo re-picks opcode
// ---------------------------------------------------------------------------
module alu_operand_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] data_in,
    input  logic         enter_pulse,
    input  logic         undo_pulse,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_status,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [1:0]   alu_opcode,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         result_valid,
    output logic [N-1:0] display_value,
    output logic [3:0]   state_leds
);

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    localparam logic [3:0] LED_WAIT_A  = 4'b0001;
    localparam logic [3:0] LED_WAIT_B  = 4'b0010;
    localparam logic [3:0] LED_WAIT_OP = 4'b0100;
    localparam logic [3:0] LED_SHOW    = 4'b1000;

    state_t       r_state;
    logic [N-1:0] r_alu_a;
    logic [N-1:0] r_alu_b;
    logic [1:0]   r_alu_opcode;
    logic [N-1:0] r_result;
    logic [3:0]   r_flags;
    logic         r_result_valid;
    logic [3:0]   r_state_leds;

    // Both buttons in the same cycle is treated as no press at all.
    logic w_enter;
    logic w_undo;

    assign w_enter = enter_pulse & ~undo_pulse;
    assign w_undo  = undo_pulse & ~enter_pulse;

    // state_leds is registered alongside the state, so every transition
    // loads the LED pattern of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_WAIT_A;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_opcode   <= '0;
            r_result       <= '0;
            r_flags        <= '0;
            r_result_valid <= 1'b0;
            r_state_leds   <= LED_WAIT_A;
        end else begin
            case (r_state)
                S_WAIT_A: begin
                    if (w_enter) begin
                        r_alu_a      <= data_in;
                        r_state      <= S_WAIT_B;
                        r_state_leds <= LED_WAIT_B;
                    end
                end

                S_WAIT_B: begin
                    if (w_enter) begin
                        r_alu_b      <= data_in;
                        r_state      <= S_WAIT_OP;
                        r_state_leds <= LED_WAIT_OP;
                    end else if (w_undo) begin
                        r_state      <= S_WAIT_A;
                        r_state_leds <= LED_WAIT_A;
                    end
                end

                S_WAIT_OP: begin
                    if (w_enter) begin
                        r_alu_opcode <= data_in[1:0];
                        r_state      <= S_EXEC;
                        // EXEC shares the WAIT_OP LED
                        r_state_leds <= LED_WAIT_OP;
                    end else if (w_undo) begin
                        r_state      <= S_WAIT_B;
                        r_state_leds <= LED_WAIT_B;
                    end
                end

                S_EXEC: begin
                    // Opcode was registered last edge, so the ALU output has
                    // had a full cycle to settle before being sampled here.
                    r_result       <= alu_result;
                    r_flags        <= alu_status;
                    r_result_valid <= 1'b1;
                    r_state        <= S_SHOW;
                    r_state_leds   <= LED_SHOW;
                end

                S_SHOW: begin
                    if (w_enter) begin
                        r_result       <= '0;
                        r_flags        <= '0;
                        r_result_valid <= 1'b0;
                        r_state        <= S_WAIT_A;
                        r_state_leds   <= LED_WAIT_A;
                    end else if (w_undo) begin
                        r_result_valid <= 1'b0;
                        r_state        <= S_WAIT_OP;
                        r_state_leds   <= LED_WAIT_OP;
                    end
                end

                default: begin
                    r_state        <= S_WAIT_A;
                    r_state_leds   <= LED_WAIT_A;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        display_value = r_result;
        case (r_state)
            S_WAIT_A,
            S_WAIT_B:  display_value = data_in;
            S_WAIT_OP: display_value = {{(N-2){1'b0}}, data_in[1:0]};
            default:   display_value = r_result;
        endcase
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_opcode   = r_alu_opcode;
    assign result       = r_result;
    assign flags        = r_flags;
    assign result_valid = r_result_valid;
    assign state_leds   = r_state_leds;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] data_in;
    logic         enter_pulse;
    logic         undo_pulse;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_status;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_opcode;
    logic [N-1:0] result;
    logic [3:0]   flags;
    logic         result_valid;
    logic [N-1:0] display_value;
    logic [3:0]   state_leds;

    int total;
    int bad;

    alu_operand_sequencer #(.N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .enter_pulse   (enter_pulse),
        .undo_pulse    (undo_pulse),
        .alu_result    (alu_result),
        .alu_status    (alu_status),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_opcode    (alu_opcode),
        .result        (result),
        .flags         (flags),
        .result_valid  (result_valid),
        .display_value (display_value),
        .state_leds    (state_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: op 0 sub, 1 add, 2 or, 3 and; flags {msb, zero, carry, 0}
    logic [N:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        case (alu_opcode)
            2'd0: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            2'd1: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            2'd2: alu_wide = {1'b0, alu_a | alu_b};
            default: alu_wide = {1'b0, alu_a & alu_b};
        endcase
        alu_result = alu_wide[N-1:0];
        alu_status = {alu_wide[N-1], (alu_wide[N-1:0] == '0), alu_wide[N], 1'b0};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [N-1:0] d, input logic e, input logic u);
        @(negedge clk);
        data_in     = d;
        enter_pulse = e;
        undo_pulse  = u;
        @(posedge clk);
        #1;
        enter_pulse = 1'b0;
        undo_pulse  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        data_in     = '0;
        enter_pulse = 1'b0;
        undo_pulse  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // reset state
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_b", alu_b, 8'h00);
        chk("rst_opcode", alu_opcode, 2'd0);
        chk("rst_result", result, 8'h00);
        chk("rst_flags", flags, 4'h0);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_leds", state_leds, 4'b0001);

        // 1: 12 + 34, opcode entered with junk upper bits
        press(8'h12, 1'b1, 1'b0);
        chk("t1_alu_a", alu_a, 8'h12);
        chk("t1_leds_b", state_leds, 4'b0010);
        press(8'h34, 1'b1, 1'b0);
        chk("t1_alu_b", alu_b, 8'h34);
        chk("t1_leds_op", state_leds, 4'b0100);
        @(negedge clk);
        data_in = 8'hFD;
        #1;
        chk("t1_disp_op", display_value, 8'h01);
        press(8'hFD, 1'b1, 1'b0);
        chk("t1_opcode", alu_opcode, 2'd1);
        chk("t1_leds_exec", state_leds, 4'b0100);
        chk("t1_valid_exec", result_valid, 1'b0);
        tick();
        chk("t1_result", result, 8'h46);
        chk("t1_flags", flags, 4'b0000);
        chk("t1_valid", result_valid, 1'b1);
        chk("t1_leds_show", state_leds, 4'b1000);
        chk("t1_disp_show", display_value, 8'h46);

        // 4: undo from SHOW, re-pick opcode 2 (or)
        press(8'h00, 1'b0, 1'b1);
        chk("t4_leds_op", state_leds, 4'b0100);
        chk("t4_valid_undo", result_valid, 1'b0);
        chk("t4_result_kept", result, 8'h46);
        press(8'h02, 1'b1, 1'b0);
        chk("t4_opcode", alu_opcode, 2'd2);
        tick();
        chk("t4_result_or", result, 8'h36);
        chk("t4_valid", result_valid, 1'b1);
        press(8'h00, 1'b1, 1'b0);
        chk("t4_clr_result", result, 8'h00);
        chk("t4_clr_valid", result_valid, 1'b0);
        chk("t4_leds_a", state_leds, 4'b0001);
        chk("t4_a_kept", alu_a, 8'h12);
        chk("t4_op_kept", alu_opcode, 2'd2);

        // 2: FF + 01 wraps to zero with carry
        press(8'hFF, 1'b1, 1'b0);
        press(8'h01, 1'b1, 1'b0);
        press(8'h01, 1'b1, 1'b0);
        tick();
        chk("t2_result", result, 8'h00);
        chk("t2_flags", flags, 4'b0110);
        chk("t2_valid", result_valid, 1'b1);
        press(8'h00, 1'b1, 1'b0);
        chk("t2_clr_result", result, 8'h00);
        chk("t2_clr_flags", flags, 4'h0);
        chk("t2_clr_valid", result_valid, 1'b0);
        chk("t2_leds_a", state_leds, 4'b0001);
        chk("t2_a_kept", alu_a, 8'hFF);

        // 3: undo behaviour around operand A
        press(8'h05, 1'b1, 1'b0);
        chk("t3_alu_a5", alu_a, 8'h05);
        @(negedge clk);
        data_in = 8'hAB;
        #1;
        chk("t3_disp_b", display_value, 8'hAB);
        press(8'h00, 1'b0, 1'b1);
        chk("t3_leds_undo", state_leds, 4'b0001);
        chk("t3_a_retained", alu_a, 8'h05);
        press(8'h07, 1'b1, 1'b0);
        chk("t3_alu_a7", alu_a, 8'h07);
        press(8'h00, 1'b0, 1'b1);
        press(8'h00, 1'b0, 1'b1);
        chk("t3_undo_in_a_leds", state_leds, 4'b0001);
        chk("t3_undo_in_a_val", alu_a, 8'h07);

        // 4b: enter and undo together in WAIT_B hold the state
        press(8'h20, 1'b1, 1'b0);
        press(8'h99, 1'b1, 1'b1);
        chk("t4b_leds", state_leds, 4'b0010);
        chk("t4b_b_kept", alu_b, 8'h01);

        // 5: async reset in EXEC
        press(8'h10, 1'b1, 1'b0);
        press(8'h00, 1'b1, 1'b0);
        chk("t5_in_exec", state_leds, 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_exec_rst_a", alu_a, 8'h00);
        chk("t5_exec_rst_b", alu_b, 8'h00);
        chk("t5_exec_rst_leds", state_leds, 4'b0001);
        chk("t5_exec_rst_res", result, 8'h00);
        chk("t5_exec_rst_valid", result_valid, 1'b0);
        @(negedge clk);
        rst         = 1'b0;
        data_in     = 8'h33;
        enter_pulse = 1'b1;
        @(posedge clk);
        #1;
        enter_pulse = 1'b0;
        chk("t5_first_pulse_a", alu_a, 8'h33);
        chk("t5_first_pulse_leds", state_leds, 4'b0010);
        press(8'h11, 1'b1, 1'b0);
        press(8'h00, 1'b1, 1'b0);
        tick();
        chk("t5_sub_result", result, 8'h22);
        chk("t5_sub_valid", result_valid, 1'b1);

        // async reset in SHOW
        #2;
        rst = 1'b1;
        #1;
        chk("t5_show_rst_res", result, 8'h00);
        chk("t5_show_rst_flags", flags, 4'h0);
        chk("t5_show_rst_valid", result_valid, 1'b0);
        chk("t5_show_rst_leds", state_leds, 4'b0001);
        chk("t5_show_rst_op", alu_opcode, 2'd0);
        @(negedge clk);
        rst         = 1'b0;
        data_in     = 8'h44;
        enter_pulse = 1'b1;
        @(posedge clk);
        #1;
        enter_pulse = 1'b0;
        chk("t5_show_first_a", alu_a, 8'h44);
        chk("t5_show_first_leds", state_leds, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
